// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder, one bit per clock, LSB first
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a-b via two's complement.

module serial_adder_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          bit_s;
  logic          carry_next;
  logic [W-1:0]  sum_next;
  logic [W-1:0]  b_load;
  logic          carry_load;

  // Single-bit full adder on the current LSBs.
  always_comb begin
    bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (carry & a_sh[0]);
  end

  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  generate
    if (W == 1) begin : g_sum_w1
      assign sum_next = bit_s;
    end else begin : g_sum_wn
      assign sum_next = {bit_s, sum[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b_load;
            carry    <= carry_load;
            cnt      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          carry <= carry_next;
          sum   <= sum_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout      <= carry_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result stays on sum/cout after the handshake until the next load.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - randomized self-checking bench for serial_adder_seq
// Covers W=8 and W=1 instances; exercises 'sub' when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
  logic         sub;

  logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0]   a1, b1, sum1;
  logic         sub1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_seq #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_seq #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation; hold = cycles of out_ready=0 in DONE with in_valid noise.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic sv, input int hold);
    int n;
    int nb;
    logic [W-1:0] es;
    logic         ec;
    logic         s_eff;
    s_eff = sv;
`ifndef SERIAL_ADDER_SUB_EN
    s_eff = 1'b0;
`endif
    if (s_eff) begin
      es = av - bv;
      ec = (av >= bv);
    end else begin
      es = W'((int'(av) + int'(bv) + int'(cv)) % (1 << W));
      ec = ((int'(av) + int'(bv) + int'(cv)) >= (1 << W));
    end

    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_idle", in_ready, 1);

    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("in_ready_run", in_ready, 0);

    n = 0;
    nb = 0;
    while (!out_valid && n < 4 * W) begin
      if (busy) nb++;
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      tick();
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("latency_edges", n, W);
    check("busy_cycles", nb, W);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("busy_done", busy, 0);
    check("in_ready_done", in_ready, 0);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, es);
      check("hold_cout", cout, ec);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_out_valid", out_valid, 0);
    check("accept_in_ready", in_ready, 1);
    check("retained_sum", sum, es);
    check("retained_cout", cout, ec);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 0;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; out_ready1 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'h12, 8'h34, 1'b1, 1'b0, 5);

    // Abort in the third RUN cycle.
    a = 8'hC3; b = 8'h5F; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    for (int i = 0; i < 16; i++) begin
      logic [1:0] tot;
      logic       av1, bv1, cv1, sv1, es1, ec1;
      av1 = i[0]; bv1 = i[1]; cv1 = i[2]; sv1 = i[3];
`ifndef SERIAL_ADDER_SUB_EN
      sv1 = 1'b0;
`endif
      if (sv1) begin
        es1 = av1 ^ bv1;
        ec1 = (av1 >= bv1);
      end else begin
        tot = 2'(av1) + 2'(bv1) + 2'(cv1);
        es1 = tot[0];
        ec1 = tot[1];
      end
      a1 = av1; b1 = bv1; cin1 = cv1; sub1 = sv1; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      n = 0;
      while (!out_valid1 && n < 8) begin
        tick();
        n++;
      end
      check("w1_latency", n, 1);
      check("w1_sum", sum1, es1);
      check("w1_cout", cout1, ec1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("w1_in_ready", in_ready1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
